// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Brief    : 8N1 UART receive path, 8x oversampled on a bclk_8 tick enable,
//            with framing/overrun flags and a host read-acknowledge handshake.
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int DATA_BITS   = 8,
    parameter int OVS         = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 sysclk,
    input  logic                 rst,
    input  logic                 bclk_8,
    input  logic                 rxd,
    input  logic                 rd_ackH,
    output logic [DATA_BITS-1:0] RDR,
    output logic                 rdrf,
    output logic                 fe,
    output logic                 oe,
    output logic                 rxd_doneH
);

    localparam int SCT_W = (OVS > 1) ? $clog2(OVS) : 1;
    localparam int BCT_W = $clog2(DATA_BITS + 1);

    localparam logic [SCT_W-1:0] c_SCT_HALF = SCT_W'(OVS / 2 - 1);
    localparam logic [SCT_W-1:0] c_SCT_LAST = SCT_W'(OVS - 1);
    localparam logic [BCT_W-1:0] c_BCT_LAST = BCT_W'(DATA_BITS - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START_CHK = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_STOP      = 3'd3;
    localparam logic [2:0] c_BRK_WAIT  = 3'd4;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_bclk_d;
    logic [2:0]             r_state;
    logic [SCT_W-1:0]       r_sct;
    logic [BCT_W-1:0]       r_bct;
    logic [DATA_BITS-1:0]   r_rsr;

    logic w_rxd_s;
    logic w_tick;
    logic w_load;

    assign w_rxd_s = r_sync[SYNC_STAGES-1];
    assign w_tick  = bclk_8 & ~r_bclk_d;
    assign w_load  = w_tick && (r_state == c_STOP) && (r_sct == c_SCT_LAST);

    // Synchroniser resets to the idle line level so reset never looks like a start bit
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_sync   <= '1;
            r_bclk_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], rxd};
            r_bclk_d <= bclk_8;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_sct   <= '0;
            r_bct   <= '0;
            r_rsr   <= '0;
        end else if (w_tick) begin
            case (r_state)
                c_IDLE: begin
                    if (!w_rxd_s) begin
                        r_state <= c_START_CHK;
                        r_sct   <= '0;
                    end
                end
                c_START_CHK: begin
                    if (r_sct == c_SCT_HALF) begin
                        r_sct   <= '0;
                        r_bct   <= '0;
                        r_state <= w_rxd_s ? c_IDLE : c_DATA;
                    end else begin
                        r_sct <= r_sct + 1'b1;
                    end
                end
                c_DATA: begin
                    if (r_sct == c_SCT_LAST) begin
                        r_rsr <= {w_rxd_s, r_rsr[DATA_BITS-1:1]};
                        r_sct <= '0;
                        r_bct <= r_bct + 1'b1;
                        if (r_bct == c_BCT_LAST) begin
                            r_state <= c_STOP;
                        end
                    end else begin
                        r_sct <= r_sct + 1'b1;
                    end
                end
                c_STOP: begin
                    if (r_sct == c_SCT_LAST) begin
                        r_sct   <= '0;
                        r_state <= w_rxd_s ? c_IDLE : c_BRK_WAIT;
                    end else begin
                        r_sct <= r_sct + 1'b1;
                    end
                end
                c_BRK_WAIT: begin
                    // A held-low break must return high before a new start is accepted
                    if (w_rxd_s) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // A load takes priority over a simultaneous host acknowledge
    always_ff @(posedge sysclk) begin
        if (rst) begin
            RDR       <= '0;
            rdrf      <= 1'b0;
            fe        <= 1'b0;
            oe        <= 1'b0;
            rxd_doneH <= 1'b0;
        end else begin
            rxd_doneH <= w_load;
            if (w_load) begin
                RDR  <= r_rsr;
                rdrf <= 1'b1;
                fe   <= ~w_rxd_s;
                oe   <= rdrf & ~rd_ackH;
            end else if (rd_ackH) begin
                rdrf <= 1'b0;
                fe   <= 1'b0;
                oe   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
